// File: rtl/pico_ctrl_pkg.sv
// Shared opcodes, condition modes, FSM encoding and instruction field-width helpers
// for the pico_ctrl_seq sequencer.
package pico_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_JUMP  = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_HALT  = 3'd5;

    localparam logic [1:0] CM_ALWAYS = 2'd0;
    localparam logic [1:0] CM_NEVER  = 2'd1;
    localparam logic [1:0] CM_EQ0    = 2'd2;
    localparam logic [1:0] CM_EQ1    = 2'd3;

    // Selector fields are never narrower than one bit, even for a single input/register.
    function automatic int csel_w(input int num_cond);
        if (num_cond <= 1) begin
            return 1;
        end else begin
            return $clog2(num_cond);
        end
    endfunction

    function automatic int rsel_w(input int num_out);
        if (num_out <= 1) begin
            return 1;
        end else begin
            return $clog2(num_out);
        end
    endfunction

    function automatic int instr_w(input int data_w, input int num_cond, input int num_out);
        return 3 + 2 + csel_w(num_cond) + rsel_w(num_out) + data_w;
    endfunction

endpackage

// File: rtl/pico_ctrl_stack.sv
// Small LIFO holding CALL return addresses; top of stack is visible combinationally.
module pico_ctrl_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] top_idx_s;

    assign wr_idx_s  = cnt_q[IDX_W-1:0];
    assign top_idx_s = IDX_W'(cnt_q - CNT_W'(1));
    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == {CNT_W{1'b0}});
    assign data_o    = mem_q[top_idx_s];

    // Entry storage and fill count; clear only resets the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (clr_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (push_i && !full_o) begin
            mem_q[wr_idx_s] <= data_i;
            cnt_q           <= cnt_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pico_ctrl_seq.sv
// Programmable condition-gated sequencer: loadable program RAM, 2-cycle FETCH/EXEC core,
// bank of output registers. Define PICO_CTRL_CALL_STACK_EN to enable CALL/RET.
module pico_ctrl_seq
    import pico_ctrl_pkg::*;
#(
    parameter int  ADDR_W      = 5,
    parameter int  DATA_W      = 8,
    parameter int  NUM_COND    = 2,
    parameter int  NUM_OUT     = 2,
    parameter int  STACK_DEPTH = 4,
    localparam int INSTR_W     = instr_w(DATA_W, NUM_COND, NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      run,
    input  logic [NUM_COND-1:0]       cond_in,
    input  logic                      prog_we,
    input  logic [ADDR_W-1:0]         prog_addr,
    input  logic [INSTR_W-1:0]        prog_wdata,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]         pc_o,
    output logic                      busy,
    output logic                      halted,
    output logic                      err
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CSEL_W = csel_w(NUM_COND);
    localparam int RSEL_W = rsel_w(NUM_OUT);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rdata_q;

    logic [NUM_COND-1:0] sync1_q;
    logic [NUM_COND-1:0] csync_q;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              pc_q, pc_d;
    logic [NUM_OUT-1:0][DATA_W-1:0] out_q, out_d;
    logic                           err_q, err_d;

    logic [2:0]        op_s;
    logic [1:0]        cmode_s;
    logic [CSEL_W-1:0] csel_s;
    logic [RSEL_W-1:0] rsel_s;
    logic [DATA_W-1:0] imm_s;
    logic [ADDR_W-1:0] pc_plus1_s;
    logic              cond_bit_s;
    logic              cond_valid_s;
    logic              taken_s;
    logic [NUM_OUT-1:0] wr_hit_s;
    logic              wr_any_s;
    logic              write_en_s;

`ifdef PICO_CTRL_CALL_STACK_EN
    logic              stk_push_s;
    logic              stk_pop_s;
    logic              stk_clr_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic [ADDR_W-1:0] stk_top_s;
`endif

    assign {op_s, cmode_s, csel_s, rsel_s, imm_s} = rdata_q;
    assign pc_plus1_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Program RAM: read-before-write, read port sampled only in FETCH.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_wdata;
        end
        if (state_q == ST_FETCH) begin
            rdata_q <= mem_q[pc_q];
        end
    end

    // Two-stage synchroniser for the asynchronous condition inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= {NUM_COND{1'b0}};
            csync_q <= {NUM_COND{1'b0}};
        end else begin
            sync1_q <= cond_in;
            csync_q <= sync1_q;
        end
    end

    // Selector decode; out-of-range csel/rsel match nothing.
    always_comb begin
        cond_bit_s   = 1'b0;
        cond_valid_s = 1'b0;
        for (int c = 0; c < NUM_COND; c++) begin
            cond_bit_s   = cond_bit_s | ((csel_s == CSEL_W'(c)) & csync_q[c]);
            cond_valid_s = cond_valid_s | (csel_s == CSEL_W'(c));
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            wr_hit_s[k] = (rsel_s == RSEL_W'(k));
        end
        wr_any_s = |wr_hit_s;
    end

    always_comb begin
        taken_s = 1'b0;
        case (cmode_s)
            CM_ALWAYS: taken_s = 1'b1;
            CM_NEVER:  taken_s = 1'b0;
            CM_EQ0:    taken_s = cond_valid_s & ~cond_bit_s;
            CM_EQ1:    taken_s = cond_valid_s & cond_bit_s;
            default:   taken_s = 1'b0;
        endcase
    end

    // Next-state logic: sequencing, branch targets and error flagging.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        err_d      = err_q;
        write_en_s = 1'b0;
`ifdef PICO_CTRL_CALL_STACK_EN
        stk_push_s = 1'b0;
        stk_pop_s  = 1'b0;
        stk_clr_s  = 1'b0;
`endif
        if (!run) begin
            state_d = ST_IDLE;
            pc_d    = {ADDR_W{1'b0}};
`ifdef PICO_CTRL_CALL_STACK_EN
            stk_clr_s = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pc_d    = {ADDR_W{1'b0}};
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    pc_d    = pc_plus1_s;
                    if (taken_s) begin
                        case (op_s)
                            OP_NOP: begin
                                pc_d = pc_plus1_s;
                            end
                            OP_WRITE: begin
                                write_en_s = wr_any_s;
                                err_d      = err_q | ~wr_any_s;
                            end
                            OP_JUMP: begin
                                pc_d = imm_s[ADDR_W-1:0];
                            end
`ifdef PICO_CTRL_CALL_STACK_EN
                            OP_CALL: begin
                                if (stk_full_s) begin
                                    err_d = 1'b1;
                                end else begin
                                    stk_push_s = 1'b1;
                                    pc_d       = imm_s[ADDR_W-1:0];
                                end
                            end
                            OP_RET: begin
                                if (stk_empty_s) begin
                                    err_d = 1'b1;
                                end else begin
                                    stk_pop_s = 1'b1;
                                    pc_d      = stk_top_s;
                                end
                            end
`endif
                            OP_HALT: begin
                                pc_d    = pc_q;
                                state_d = ST_HALTED;
                            end
                            default: begin
                                err_d = 1'b1;
                            end
                        endcase
                    end else begin
                        pc_d = pc_plus1_s;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_IDLE;
                    pc_d    = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    always_comb begin
        out_d = out_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_d[k] = (write_en_s && wr_hit_s[k]) ? imm_s : out_q[k];
        end
    end

    // Core state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= {ADDR_W{1'b0}};
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

`ifdef PICO_CTRL_CALL_STACK_EN
    pico_ctrl_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr_i   (stk_clr_s),
        .push_i  (stk_push_s),
        .pop_i   (stk_pop_s),
        .data_i  (pc_plus1_s),
        .data_o  (stk_top_s),
        .full_o  (stk_full_s),
        .empty_o (stk_empty_s)
    );
`endif

    assign out_data = out_q;
    assign pc_o     = pc_q;
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted   = (state_q == ST_HALTED);
    assign err      = err_q;

endmodule
